wb_slave_regfile: RTL
=====================

Name: wb_slave_regfile

Overview:
Parametrised Wishbone classic slave register file, successor to the single-mode register slave.
- Adds per-register access modes: RW, read-only from hardware, and write-1-to-clear status with hardware set.
- Adds cyc_i qualification, configurable wait states, correct out-of-range decode, and hardware-facing outputs.
- Sits behind the Wishbone interconnect as the control/status block for a peripheral.

Parameters:
- ADDR_WIDTH, 16, width of adr_i; adr_i is a register index, not a byte address.
- DATA_WIDTH, 32, data bus width.
- GRANULE, 8, bits per sel_i lane; DATA_WIDTH must be a multiple of it.
- REGISTER_NUM, 16, number of registers, 1..2**ADDR_WIDTH.
- WAIT_STATES, 0, extra cycles inserted before ack/err, 0..15.
- RO_MASK, 0, REGISTER_NUM bits; bit r=1 makes register r read-only, returning hw_val_i slice r.
- W1C_MASK, 0, REGISTER_NUM bits; bit r=1 makes register r write-1-to-clear. RO_MASK takes precedence.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- adr_i  in  ADDR_WIDTH  register index
- dat_i  in  DATA_WIDTH  write data
- dat_o  out  DATA_WIDTH  read data
- sel_i  in  DATA_WIDTH/GRANULE  lane enables
- we_i  in  1  write enable
- stb_i  in  1  strobe
- cyc_i  in  1  cycle valid
- ack_o  out  1  normal termination
- err_o  out  1  error termination
- hw_val_i  in  REGISTER_NUM*DATA_WIDTH  read-only register values, register r at [r*DATA_WIDTH +: DATA_WIDTH]
- hw_set_i  in  REGISTER_NUM*DATA_WIDTH  per-bit set strobes for W1C registers; ignored elsewhere
- reg_o  out  REGISTER_NUM*DATA_WIDTH  current stored value of every register; RO slices are 0
- wr_pulse_o  out  REGISTER_NUM  one-cycle pulse per committed write

Behaviour:
Reset (rst_ni low, asynchronous):
- State goes to IDLE.
- ack_o, err_o, dat_o, reg_o, wr_pulse_o and the wait counter all go to 0 immediately, including mid-transfer.
- No access completes across reset.

State machine (state_t): IDLE, WAIT, RESP, HOLD.
- IDLE: when cyc_i&stb_i is high at edge N, capture adr/dat/sel/we, load counter = WAIT_STATES. Go to WAIT if WAIT_STATES>0, else RESP.
- WAIT: decrement the counter each edge; go to RESP when it reaches 1. If cyc_i is low at any edge, abort to IDLE with no access and no ack.
- RESP: perform the access and set exactly one of ack/err. Go to HOLD. ack_o/err_o first seen high after edge N+1+WAIT_STATES.
- HOLD: hold ack_o/err_o and dat_o until an edge with stb_i low or cyc_i low. Then clear ack_o/err_o (dat_o returns to 0) and go to IDLE. A new strobe is sampled no earlier than the edge after returning to IDLE.

Decode (evaluated in RESP):
- Index >= REGISTER_NUM -> err, no effect. This fixes the old off-by-one: index == REGISTER_NUM errors.
- Write to an RO register -> err, no effect.
- Read of an RO register -> ack, dat_o = hw_val_i sampled at the RESP edge.

Write with enabled lanes:
- RW: selected lanes replaced.
- W1C: in selected lanes, bits written 1 clear; bits written 0 unchanged.
- wr_pulse_o[r] is high for exactly the cycle after the RESP edge, only for an acked write to a non-RO register, even if sel_i==0.
- sel_i==0 write -> ack, no data change.

Read: dat_o unselected lanes = 0; selected lanes = stored or hw value.

W1C set/clear:
- hw_set_i sets bits every cycle regardless of bus state.
- A bit with both hardware set and bus clear on the same edge ends set (set wins).

Decomposition:
- Package wb_regfile_pkg holds state_t, the derived SEL_WIDTH constant, and a lane-mask expansion function (sel -> bit mask).
- Sub-module wb_regfile_cell: one register with mode parameters (RO/W1C), write-enable, lane mask, data and hw_set inputs. Instantiated REGISTER_NUM times via generate.
- Top level holds the FSM, wait counter, decode and read mux.

Test Plan:
All scenarios use defaults except where noted: REGISTER_NUM=16, RO_MASK=16'h0002, W1C_MASK=16'h0004.
1. Write 0xDEADBEEF to index 0 with sel=4'hF, WAIT_STATES=0 -> ack high after edge N+1, wr_pulse_o[0] one cycle, reg_o[31:0]=0xDEADBEEF. Read back with sel=4'h3 -> dat_o=0x0000BEEF.
2. Write index 1 (RO) -> err_o, no wr_pulse. Read index 1 with hw_val_i slice=0x12345678 -> ack, dat_o=0x12345678.
3. Set index 2 via hw_set_i=0x000000FF, write 0x0000000F sel=4'h1 -> reg=0x000000F0. Then clear bit 4 while hw_set_i bit 4 pulses on the same edge -> bit 4 remains 1.
4. Access index 16 and index 0xFFFF -> err_o, no register changes.
5. WAIT_STATES=3: ack after edge N+4. Drop cyc_i during WAIT -> no ack/err, register unchanged, next transfer completes normally.
6. Assert rst_ni low while in HOLD with ack high -> ack_o/err_o/dat_o/reg_o go to 0 without a clock edge. After release, state is IDLE.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared types and helpers for the Wishbone register file.
//   state_t    : bus FSM states
//   SEL_WIDTH  : lane-enable width for the default 32-bit bus with 8-bit lanes
//   lane_mask  : expands a lane-enable vector into a per-bit mask
package wb_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    HOLD
  } state_t;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_GRANULE    = 8;
  localparam int unsigned SEL_WIDTH          = DEFAULT_DATA_WIDTH / DEFAULT_GRANULE;

  // Wait counter covers WAIT_STATES up to 15.
  localparam int unsigned CNT_WIDTH = 4;

  // Widest data bus the lane_mask helper supports; callers cast to their width.
  localparam int unsigned MAX_DATA_WIDTH = 256;
  localparam int unsigned MAX_IDX_WIDTH  = 8;

  // Bit i of the result is lane enable (i / granule).
  function automatic logic [MAX_DATA_WIDTH-1:0] lane_mask(
    input logic [MAX_DATA_WIDTH-1:0] sel,
    input int unsigned               granule
  );
    logic [MAX_DATA_WIDTH-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) begin
      mask[MAX_IDX_WIDTH'(i)] = sel[MAX_IDX_WIDTH'(i / granule)];
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_regfile_cell.sv
// One register of the file, behaviour selected by mode parameters.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   we            : bus write commit for this register (one cycle)
//   mask_bits     : per-bit lane mask of the write
//   wdata         : bus write data
//   hw_set        : per-bit hardware set strobes (W1C mode only)
//   q             : stored value (constant 0 in RO mode)
module wb_regfile_cell
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          RO         = 1'b0,
  parameter bit          W1C        = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] mask_bits,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] hw_set,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] q_d;
  logic [DATA_WIDTH-1:0] clr_bits;

  // Inputs only some modes consume.
  logic unused_in;
  assign unused_in = ^{we, mask_bits, wdata, hw_set};

  assign clr_bits = mask_bits & wdata & {DATA_WIDTH{we}};

  // Next value: RO holds nothing, W1C clears then sets (set wins), RW merges lanes.
  always_comb begin
    q_d = q;
    if (RO) begin
      q_d = '0;
    end else if (W1C) begin
      q_d = (q & ~clr_bits) | hw_set;
    end else if (we) begin
      q_d = (q & ~mask_bits) | (wdata & mask_bits);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone classic slave register file with RW, RO and W1C registers.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   adr_i           : register index (not a byte address)
//   dat_i / dat_o   : write / read data; dat_o is 0 outside a response
//   sel_i           : lane enables, GRANULE bits each
//   we_i, stb_i, cyc_i : Wishbone request qualifiers
//   ack_o / err_o   : normal / error termination, held until stb_i or cyc_i drops
//   hw_val_i        : values returned for read-only registers
//   hw_set_i        : per-bit set strobes for W1C registers
//   reg_o           : stored value of every register (RO slices are 0)
//   wr_pulse_o      : one-cycle pulse per committed write
module wb_slave_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH   = 16,
  parameter int unsigned             DATA_WIDTH   = 32,
  parameter int unsigned             GRANULE      = 8,
  parameter int unsigned             REGISTER_NUM = 16,
  parameter int unsigned             WAIT_STATES  = 0,
  parameter logic [REGISTER_NUM-1:0] RO_MASK      = '0,
  parameter logic [REGISTER_NUM-1:0] W1C_MASK     = '0
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [ADDR_WIDTH-1:0]              adr_i,
  input  logic [DATA_WIDTH-1:0]              dat_i,
  output logic [DATA_WIDTH-1:0]              dat_o,
  input  logic [DATA_WIDTH/GRANULE-1:0]      sel_i,
  input  logic                               we_i,
  input  logic                               stb_i,
  input  logic                               cyc_i,
  output logic                               ack_o,
  output logic                               err_o,
  input  logic [REGISTER_NUM*DATA_WIDTH-1:0] hw_val_i,
  input  logic [REGISTER_NUM*DATA_WIDTH-1:0] hw_set_i,
  output logic [REGISTER_NUM*DATA_WIDTH-1:0] reg_o,
  output logic [REGISTER_NUM-1:0]            wr_pulse_o
);

  localparam int unsigned SEL_W = DATA_WIDTH / GRANULE;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    we_q, we_d;
  logic                    ack_d, err_d;
  logic [DATA_WIDTH-1:0]   dat_o_d;
  logic [REGISTER_NUM-1:0] wr_pulse_d;
  logic [REGISTER_NUM-1:0] cell_we;

  logic [REGISTER_NUM-1:0]                 hit;
  logic [DATA_WIDTH-1:0]                   mask_c;
  logic [REGISTER_NUM:0][DATA_WIDTH-1:0]   rd_acc;
  logic                                    in_range;
  logic                                    hit_ro;

  // hw_val_i is only consumed for RO registers.
  logic unused_hw;
  assign unused_hw = ^hw_val_i;

  assign mask_c   = DATA_WIDTH'(lane_mask(MAX_DATA_WIDTH'(sel_q), GRANULE));
  assign in_range = |hit;
  assign hit_ro   = |(hit & RO_MASK);

  assign rd_acc[0] = '0;

  // Per-register decode, storage and read-source selection.
  for (genvar r = 0; r < REGISTER_NUM; r++) begin : g_reg
    logic [DATA_WIDTH-1:0] src;

    assign hit[r] = (adr_q == ADDR_WIDTH'(r));

    wb_regfile_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .RO         (RO_MASK[r]),
      .W1C        (W1C_MASK[r] && !RO_MASK[r])
    ) u_cell (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .we        (cell_we[r]),
      .mask_bits (mask_c),
      .wdata     (dat_q),
      .hw_set    (hw_set_i[r*DATA_WIDTH +: DATA_WIDTH]),
      .q         (reg_o[r*DATA_WIDTH +: DATA_WIDTH])
    );

    if (RO_MASK[r]) begin : g_ro
      assign src = hw_val_i[r*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_rw
      assign src = reg_o[r*DATA_WIDTH +: DATA_WIDTH];
    end

    assign rd_acc[r+1] = rd_acc[r] | (hit[r] ? src : '0);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    ack_d      = ack_o;
    err_d      = err_o;
    dat_o_d    = dat_o;
    wr_pulse_d = '0;
    cell_we    = '0;

    case (state_q)
      IDLE: begin
        if (cyc_i && stb_i) begin
          adr_d   = adr_i;
          dat_d   = dat_i;
          sel_d   = sel_i;
          we_d    = we_i;
          cnt_d   = CNT_WIDTH'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!cyc_i) begin
          // Master abandoned the cycle: drop it without touching any register.
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        state_d = HOLD;
        if (!in_range || (we_q && hit_ro)) begin
          err_d = 1'b1;
        end else begin
          ack_d = 1'b1;
          if (we_q) begin
            cell_we    = hit;
            wr_pulse_d = hit;
          end else begin
            dat_o_d = rd_acc[REGISTER_NUM] & mask_c;
          end
        end
      end
      HOLD: begin
        if (!stb_i || !cyc_i) begin
          ack_d   = 1'b0;
          err_d   = 1'b0;
          dat_o_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      ack_o      <= 1'b0;
      err_o      <= 1'b0;
      dat_o      <= '0;
      wr_pulse_o <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      ack_o      <= ack_d;
      err_o      <= err_d;
      dat_o      <= dat_o_d;
      wr_pulse_o <= wr_pulse_d;
    end
  end

endmodule
